// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction-fetch stage with imem req/ack, IF/ID register and one-entry skid
// Fetch PC, word request to instruction memory, and IF/ID register with stall, redirect and skid.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        id_stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_id_valid,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc4,
   output logic [31:0] pc_out
);

   typedef enum logic {
      S_REQ  = 1'b0,
      S_HOLD = 1'b1
   } state_t;

   localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

   state_t      r_state;
   logic [31:0] r_pc;
   logic        r_if_id_valid;
   logic [31:0] r_if_id_instr;
   logic [31:0] r_if_id_pc4;
   logic [31:0] r_skid_instr;
   logic [31:0] r_skid_pc4;

   state_t      w_state_nx;
   logic [31:0] w_pc_nx;
   logic        w_if_id_valid_nx;
   logic [31:0] w_if_id_instr_nx;
   logic [31:0] w_if_id_pc4_nx;
   logic [31:0] w_skid_instr_nx;
   logic [31:0] w_skid_pc4_nx;

   logic        w_slot_free;
   logic [31:0] w_pc_inc;
   logic [31:0] w_redirect_target;

   // Decode can take a new word when IF/ID is empty or is being consumed now.
   assign w_slot_free       = !r_if_id_valid || !id_stall;
   assign w_pc_inc          = r_pc + 32'd4;
   assign w_redirect_target = redirect_pc & 32'hFFFF_FFFC;

   assign imem_req    = (r_state == S_REQ) && !rst;
   assign imem_addr   = r_pc;
   assign pc_out      = r_pc;
   assign if_id_valid = r_if_id_valid;
   assign if_id_instr = r_if_id_instr;
   assign if_id_pc4   = r_if_id_pc4;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_REQ;
         r_pc          <= RESET_PC_ALIGNED;
         r_if_id_valid <= 1'b0;
         r_if_id_instr <= 32'd0;
         r_if_id_pc4   <= 32'd0;
         r_skid_instr  <= 32'd0;
         r_skid_pc4    <= 32'd0;
      end else begin
         r_state       <= w_state_nx;
         r_pc          <= w_pc_nx;
         r_if_id_valid <= w_if_id_valid_nx;
         r_if_id_instr <= w_if_id_instr_nx;
         r_if_id_pc4   <= w_if_id_pc4_nx;
         r_skid_instr  <= w_skid_instr_nx;
         r_skid_pc4    <= w_skid_pc4_nx;
      end
   end

   always_comb begin
      w_state_nx       = r_state;
      w_pc_nx          = r_pc;
      w_if_id_valid_nx = r_if_id_valid;
      w_if_id_instr_nx = r_if_id_instr;
      w_if_id_pc4_nx   = r_if_id_pc4;
      w_skid_instr_nx  = r_skid_instr;
      w_skid_pc4_nx    = r_skid_pc4;

      if (redirect_valid) begin
         // Returning to REQ abandons the skid word; same-cycle ack data is dropped.
         w_pc_nx          = w_redirect_target;
         w_if_id_valid_nx = 1'b0;
         w_state_nx       = S_REQ;
      end else begin
         case (r_state)
            S_REQ: begin
               if (imem_ack) begin
                  w_pc_nx = w_pc_inc;
                  if (w_slot_free) begin
                     w_if_id_instr_nx = imem_rdata;
                     w_if_id_pc4_nx   = w_pc_inc;
                     w_if_id_valid_nx = 1'b1;
                  end else begin
                     w_skid_instr_nx = imem_rdata;
                     w_skid_pc4_nx   = w_pc_inc;
                     w_state_nx      = S_HOLD;
                  end
               end else if (w_slot_free) begin
                  w_if_id_valid_nx = 1'b0;
               end
            end
            S_HOLD: begin
               if (w_slot_free) begin
                  w_if_id_instr_nx = r_skid_instr;
                  w_if_id_pc4_nx   = r_skid_pc4;
                  w_if_id_valid_nx = 1'b1;
                  w_state_nx       = S_REQ;
               end
            end
            default: w_state_nx = S_REQ;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized self-checking bench for fetch_stage against a queue-based model
module tb_fetch_stage;

   localparam logic [31:0] P_RESET_PC = 32'h0000_0102;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        id_stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_id_valid;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc4;
   logic [31:0] pc_out;

   fetch_stage #(.RESET_PC(P_RESET_PC)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .id_stall       (id_stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_id_valid    (if_id_valid),
      .if_id_instr    (if_id_instr),
      .if_id_pc4      (if_id_pc4),
      .pc_out         (pc_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] memf(input logic [31:0] a);
      return 32'h1000_0000 + (a >> 2) + {a[31:24], 24'd0};
   endfunction

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc4;
   } fetched_t;

   // Model: architectural PC, decode register, and a list of fetched words waiting for decode.
   logic [31:0] m_pc = P_RESET_PC & 32'hFFFF_FFFC;
   logic        m_valid = 1'b0;
   logic [31:0] m_instr = 32'd0;
   logic [31:0] m_pc4 = 32'd0;
   fetched_t    m_wait[$];

   task automatic step(input logic r, input logic st, input logic rd,
                       input logic [31:0] rpc, input logic ack_en);
      logic     m_req;
      logic     slot_free;
      fetched_t f;
      @(negedge clk);
      rst            = r;
      id_stall       = st;
      redirect_valid = rd;
      redirect_pc    = rpc;
      m_req          = !r && (m_wait.size() == 0);
      imem_ack       = ack_en && m_req;
      #1;
      imem_rdata = memf(imem_addr);
      chk("imem_req", {31'd0, imem_req}, {31'd0, m_req});
      chk("imem_addr", imem_addr, m_pc);
      chk("pc_out", pc_out, m_pc);
      chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
      chk("if_id_instr", if_id_instr, m_instr);
      chk("if_id_pc4", if_id_pc4, m_pc4);
      if (m_valid) chk("instr_matches_addr", if_id_instr, memf(m_pc4 - 32'd4));

      if (r) begin
         m_pc    = P_RESET_PC & 32'hFFFF_FFFC;
         m_valid = 1'b0;
         m_instr = 32'd0;
         m_pc4   = 32'd0;
         m_wait.delete();
      end else if (rd) begin
         m_pc    = rpc & 32'hFFFF_FFFC;
         m_valid = 1'b0;
         m_wait.delete();
      end else begin
         slot_free = !m_valid || !st;
         if (m_wait.size() > 0) begin
            if (slot_free) begin
               f       = m_wait.pop_front();
               m_instr = f.instr;
               m_pc4   = f.pc4;
               m_valid = 1'b1;
            end
         end else if (imem_ack) begin
            f.instr = memf(m_pc);
            f.pc4   = m_pc + 32'd4;
            m_pc    = m_pc + 32'd4;
            if (slot_free) begin
               m_instr = f.instr;
               m_pc4   = f.pc4;
               m_valid = 1'b1;
            end else begin
               m_wait.push_back(f);
            end
         end else if (slot_free) begin
            m_valid = 1'b0;
         end
      end
   endtask

   initial begin
      rst            = 1'b1;
      id_stall       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      imem_ack       = 1'b0;
      imem_rdata     = 32'd0;
      repeat (2) @(posedge clk);

      step(1, 0, 0, 0, 1);
      chk("reset_req_low", {31'd0, imem_req}, 32'd0);
      chk("reset_pc_aligned", pc_out, 32'h0000_0100);

      // Zero-wait streaming, then stall with an ack to force the skid.
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 1);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);

      // Redirect on an ack cycle to a misaligned target.
      step(0, 0, 1, 32'h0000_0043, 1);
      step(0, 0, 0, 0, 1);
      chk("redir_addr", imem_addr, 32'h0000_0040);
      chk("redir_bubble", {31'd0, if_id_valid}, 32'd0);
      step(0, 0, 0, 0, 0);
      chk("redir_first_pc4", if_id_pc4, 32'h0000_0044);
      chk("redir_first_instr", if_id_instr, memf(32'h0000_0040));

      // Redirect while holding a skid entry.
      step(0, 1, 0, 0, 1);
      step(0, 1, 0, 0, 1);
      step(0, 1, 1, 32'h0000_0200, 0);
      step(0, 0, 0, 0, 1);
      chk("hold_redir_addr", imem_addr, 32'h0000_0200);

      // PC wrap at the top of the address space.
      step(0, 0, 1, 32'hFFFF_FFFF, 0);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0);
      chk("wrap_pc4", if_id_pc4, 32'h0000_0000);
      chk("wrap_addr", imem_addr, 32'h0000_0000);

      // Reset in the middle of HOLD.
      step(0, 1, 0, 0, 1);
      step(0, 1, 0, 0, 1);
      step(1, 1, 0, 0, 1);
      step(0, 0, 0, 0, 0);
      chk("rst_hold_valid", {31'd0, if_id_valid}, 32'd0);
      chk("rst_hold_req", {31'd0, imem_req}, 32'd1);

      // Random phases: fast memory, slow memory, heavy stall, everything mixed.
      for (int p = 0; p < 4; p++) begin
         for (int i = 0; i < 600; i++) begin
            logic        r_r, r_st, r_rd, r_ack;
            logic [31:0] r_pc;
            r_ack = (p == 1) ? ($urandom_range(3) == 0) : ($urandom_range(9) < 8);
            r_st  = (p == 2) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
            r_rd  = (p == 3) ? ($urandom_range(9) == 0) : ($urandom_range(99) == 0);
            r_r   = (p == 3) && ($urandom_range(99) == 0);
            r_pc  = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15)) : $urandom;
            step(r_r, r_st, r_rd, r_pc, r_ack);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
